serial_adder: RTL and testbench

- Parametrised multi-cycle adder/subtractor. Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, LSB first, using one DIGIT-bit ripple slice built from half-adder pairs with a registered carry between cycles.
- Trades latency for area; it is the sequential successor to the team's combinational half adder.
- Sits behind a start/done handshake so control FSMs can issue operations back-to-back.

---
 rtl/serial_adder.sv | 138 +++++++++++++
 tb/tb_serial_adder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock, LSB first, through one ripple
// slice of half-adder pairs with the carry held in a register between cycles.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  localparam int STEPS = (DIGIT > 0) ? WIDTH / DIGIT : 1;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (DIGIT < 1 || WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_adder: WIDTH must be >= 2 and an integer multiple of DIGIT");
  end

  // Handshake: start is accepted on a rising edge only while the state is IDLE
  // or DONE; busy is high exactly in RUN and done is high exactly in DONE (one cycle).
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0]       r_a;
  logic [WIDTH-1:0]       r_b;
  logic                   r_carry;
  logic [CW-1:0]          r_cnt;
  logic [WIDTH-1:0]       r_res;
  logic [WIDTH-1:0]       r_sum;
  logic                   r_cout;
  logic                   r_ovf;

  logic                   w_accept;
  logic                   w_last;
  logic [DIGIT-1:0]       w_s;
  logic                   w_cout;
  logic                   w_cin_msb;
  logic [WIDTH+DIGIT-1:0] w_res_wide;
  logic [WIDTH-1:0]       w_res_next;

  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last   = (r_cnt == LAST);

  // Full adder per bit = two half adders whose carries are ORed.
  always_comb begin
    logic       c;
    logic [1:0] h1;
    logic [1:0] h2;
    w_s       = '0;
    w_cin_msb = 1'b0;
    c         = r_carry;
    for (int i = 0; i < DIGIT; i++) begin
      h1 = half_add(r_a[i], r_b[i]);
      h2 = half_add(h1[0], c);
      w_s[i] = h2[0];
      if (i == DIGIT - 1) w_cin_msb = c;
      c = h1[1] | h2[1];
    end
    w_cout = c;
  end

  // New digit enters at the top so the first digit ends at the LSB after STEPS shifts.
  assign w_res_wide = {w_s, r_res};
  assign w_res_next = w_res_wide[WIDTH+DIGIT-1:DIGIT];

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = w_accept ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtract as a + ~b + 1: invert B and seed the carry with sub.
      r_a     <= a;
      r_b     <= b ^ {WIDTH{sub}};
      r_carry <= sub;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_carry <= w_cout;
      r_cnt   <= r_cnt + CW'(1);
      r_res   <= w_res_next;
      if (w_last) begin
        r_sum  <= w_res_next;
        r_cout <= w_cout;
        r_ovf  <= w_cin_msb ^ w_cout;
      end
    end
  end

  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign sum       = r_sum;
  assign carry_out = r_cout;
  assign overflow  = r_ovf;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit/1-bit-digit instance and a
// 16-bit/4-bit-digit instance, checked through per-instance expected queues.
module tb_serial_adder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // 8-bit instance
  logic        start8 = 1'b0, sub8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, sum8;
  logic        busy8, done8, cout8, ovf8;
  logic [1:0]  st8;
  logic [9:0]  exp_q8[$];
  logic [9:0]  last8 = '0;

  // 16-bit instance
  logic        start16 = 1'b0, sub16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic        busy16, done16, cout16, ovf16;
  logic [1:0]  st16;
  logic [17:0] exp_q16[$];
  logic [17:0] last16 = '0;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(cout8),
    .overflow(ovf8), .dbg_state(st8)
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .sum(sum16), .carry_out(cout16),
    .overflow(ovf16), .dbg_state(st16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Expected value layout: {carry_out, overflow, sum}.
  task automatic launch8(input logic [7:0] xa, input logic [7:0] xb, input logic xs,
                         input logic [9:0] exp, input bit push, input bit hold);
    if (push) exp_q8.push_back(exp);
    a8 = xa; b8 = xb; sub8 = xs; start8 = 1'b1;
    @(posedge clk); #1;
    if (!hold) start8 = 1'b0;
  endtask

  // Called #1 after the accepting edge; returns #1 after the edge that enters DONE.
  task automatic run8(input string name, input int drop_at);
    for (int i = 0; i < 8; i++) begin
      if (i == drop_at) start8 = 1'b0;
      check($sformatf("%s busy[%0d]", name, i), 32'(busy8), 32'd1);
      if (i == 0) check($sformatf("%s state_run", name), 32'(st8), 32'd1);
      @(posedge clk); #1;
    end
    check($sformatf("%s done", name), 32'(done8), 32'd1);
    check($sformatf("%s busy_end", name), 32'(busy8), 32'd0);
  endtask

  task automatic launch16(input logic [15:0] xa, input logic [15:0] xb, input logic xs,
                          input logic [17:0] exp);
    exp_q16.push_back(exp);
    a16 = xa; b16 = xb; sub16 = xs; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    a16 = ~xa; b16 = ~xb; sub16 = ~xs;
  endtask

  task automatic run16(input string name);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s busy[%0d]", name, i), 32'(busy16), 32'd1);
      @(posedge clk); #1;
    end
    check($sformatf("%s done", name), 32'(done16), 32'd1);
    check($sformatf("%s busy_end", name), 32'(busy16), 32'd0);
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (reset) begin
      last8 = '0;
    end else if (done8) begin
      if (exp_q8.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL done8_unexpected: got done=1 sum=%h expected no done", sum8);
      end else begin
        logic [9:0] e;
        e = exp_q8.pop_front();
        check("result8", 32'({cout8, ovf8, sum8}), 32'(e));
        last8 = e;
      end
    end else if (busy8) begin
      check("hold8", 32'({cout8, ovf8, sum8}), 32'(last8));
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      last16 = '0;
    end else if (done16) begin
      if (exp_q16.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL done16_unexpected: got done=1 sum=%h expected no done", sum16);
      end else begin
        logic [17:0] e;
        e = exp_q16.pop_front();
        check("result16", 32'({cout16, ovf16, sum16}), 32'(e));
        last16 = e;
      end
    end else if (busy16) begin
      check("hold16", 32'({cout16, ovf16, sum16}), 32'(last16));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst busy8", 32'(busy8), 32'd0);
    check("rst done8", 32'(done8), 32'd0);
    check("rst out8", 32'({cout8, ovf8, sum8}), 32'd0);
    check("rst state8", 32'(st8), 32'd0);
    check("rst out16", 32'({busy16, done16, cout16, ovf16, sum16}), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 8-bit directed vectors, each returning to IDLE
    launch8(8'h0F, 8'h01, 1'b0, {1'b0, 1'b0, 8'h10}, 1, 0); run8("add_0f_01", 99);
    @(posedge clk); #1;
    check("idle after done", 32'(st8), 32'd0);
    launch8(8'hFF, 8'h01, 1'b0, {1'b1, 1'b0, 8'h00}, 1, 0); run8("add_ff_01", 99);
    @(posedge clk); #1;
    launch8(8'h7F, 8'h01, 1'b0, {1'b0, 1'b1, 8'h80}, 1, 0); run8("add_7f_01", 99);
    @(posedge clk); #1;
    launch8(8'h05, 8'h07, 1'b1, {1'b0, 1'b0, 8'hFE}, 1, 0); run8("sub_05_07", 99);
    @(posedge clk); #1;
    launch8(8'h80, 8'h01, 1'b1, {1'b1, 1'b1, 8'h7F}, 1, 0); run8("sub_80_01", 99);
    @(posedge clk); #1;
    launch8(8'h00, 8'h00, 1'b1, {1'b1, 1'b0, 8'h00}, 1, 0); run8("sub_00_00", 99);
    @(posedge clk); #1;

    // start held and operands changed mid-RUN must not disturb the operation
    launch8(8'h12, 8'h34, 1'b0, {1'b0, 1'b0, 8'h46}, 1, 1);
    a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1;
    run8("ignore_start", 5);
    @(posedge clk); #1;

    // back-to-back: second start issued during the DONE cycle
    launch8(8'h40, 8'h40, 1'b0, {1'b0, 1'b1, 8'h80}, 1, 0); run8("b2b_first", 99);
    launch8(8'h03, 8'h02, 1'b1, {1'b1, 1'b0, 8'h01}, 1, 0); run8("b2b_second", 99);
    @(posedge clk); #1;

    // reset mid-operation: aborted, no done pulse afterwards
    launch8(8'h11, 8'h22, 1'b0, '0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort busy8", 32'(busy8), 32'd0);
    check("abort done8", 32'(done8), 32'd0);
    check("abort out8", 32'({cout8, ovf8, sum8}), 32'd0);
    repeat (12) @(posedge clk);
    #1;
    check("abort stays idle", 32'(st8), 32'd0);

    // 16-bit, 4 bits per cycle
    launch16(16'hABCD, 16'h1234, 1'b0, {1'b0, 1'b0, 16'hBE01}); run16("w16_abcd_1234");
    @(posedge clk); #1;
    launch16(16'hFFFF, 16'hFFFF, 1'b0, {1'b1, 1'b0, 16'hFFFE}); run16("w16_ffff_ffff");
    @(posedge clk); #1;
    launch16(16'h7FFF, 16'h0001, 1'b0, {1'b0, 1'b1, 16'h8000}); run16("w16_7fff_0001");
    launch16(16'h1000, 16'h2000, 1'b1, {1'b0, 1'b0, 16'hF000}); run16("w16_sub_b2b");
    @(posedge clk); #1;

    repeat (4) @(posedge clk);
    #1;
    check("q8 drained", 32'(exp_q8.size()), 32'd0);
    check("q16 drained", 32'(exp_q16.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
